tone_gen_multi: RTL and testbench
=================================

TONE_GEN_MULTI -- requirements
Module: tone_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent tone channels (1..8).
REQ-002 Parameter CNT_W, default 32, width of the period/duty counters.
REQ-003 Parameter DUR_W, default 16, width of the note-duration counter, counted in completed periods.
REQ-004 Port clk  input  1  single system clock; all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port cfg_valid  input  1  configuration write request.
REQ-007 Port cfg_ready  output  1  write accepted when cfg_valid && cfg_ready.
REQ-008 Port cfg_ch  input  3  target channel index.
REQ-009 Port cfg_period  input  CNT_W  wrap value; 0 = channel silent.
REQ-010 Port cfg_duty  input  CNT_W  threshold; output high while count > threshold.
REQ-011 Port cfg_dur  input  DUR_W  periods to play; 0 = play forever.
REQ-012 Port ch_out  output  NUM_CH  per-channel square wave.
REQ-013 Port mix_out  output  1  OR of all ch_out bits.
REQ-014 Port ch_active  output  NUM_CH  channel currently playing.
REQ-015 Port done_pulse  output  NUM_CH  one-cycle pulse when a note's duration expires.

Function
- REQ-016 Each channel SHALL hold count, period, duty, remaining-duration and a one-deep pending slot.
- REQ-017 Active channel SHALL increment count each cycle; count == period SHALL wrap to 0 next cycle (period+1 cycles per wave).
- REQ-018 ch_out[i] SHALL be registered, equal to (count > duty) && active; duty >= period SHALL give constant 0.
- REQ-019 Write to an idle channel SHALL load period/duty/dur immediately, count <= 0, active <= (period != 0), first ch_out update one cycle later.
- REQ-020 Write to an active channel SHALL enter the pending slot and apply at that channel's next wrap (glitch-free), count restarting at 0.
- REQ-021 cfg_ready SHALL be low iff the addressed cfg_ch channel has a pending write occupied; combinational from cfg_ch and pending flags.
- REQ-022 cfg_ch >= NUM_CH SHALL be accepted (cfg_ready high) and silently dropped.
- REQ-023 Remaining duration SHALL decrement at each wrap when nonzero at load; on reaching 0 channel SHALL go idle, ch_out 0, done_pulse[i] high exactly one cycle.
- REQ-024 Pending write applied at the expiring wrap SHALL take precedence: channel reloads, no done_pulse.
- REQ-025 Writing period 0 SHALL stop the channel at application time with no done_pulse.
- REQ-026 Channels SHALL be fully independent; simultaneous wraps/expiries on multiple channels SHALL all be honoured in the same cycle.

Reset
- REQ-027 rst_n low SHALL asynchronously clear all counters, registers, pending flags; ch_out, mix_out, ch_active, done_pulse = 0; cfg_ready = 1.
- REQ-028 Reset mid-note SHALL abort it without done_pulse; release SHALL leave all channels idle.

Configuration
- REQ-029 Macro TONE_GEN_DURATION_EN defined: duration counting and done_pulse per REQ-023/024.
- REQ-030 Macro undefined: cfg_dur ignored, no duration counter instantiated, notes play until rewritten, done_pulse tied 0.

Structure
- REQ-031 Package tone_gen_pkg SHALL hold default CNT_W/DUR_W/NUM_CH constants and the channel-config struct (period, duty, dur).
- REQ-032 Per-channel logic SHALL be sub-module tone_gen_chan, generated NUM_CH times; top holds handshake decode and OR mixer.

Verification
- REQ-033 Idle ch0 write period=9, duty=4, dur=0 -> ch_out[0] low 5 cycles, high 5 cycles, repeating; mix_out identical.
- REQ-034 ch1 write period=3, duty=1, dur=2 -> 2 waves of 4 cycles, then ch_active[1] falls, done_pulse[1] one cycle (DURATION_EN), otherwise plays on.
- REQ-035 Active ch0 (period=99), write period=9 at count=50, then second write -> first pends to wrap, cfg_ready low for cfg_ch=0 until wrap, high for cfg_ch=1.
- REQ-036 cfg_ch=5 with NUM_CH=2 -> handshake completes, no channel state changes.
- REQ-037 rst_n low mid-note on both channels -> all outputs 0 asynchronously, no done_pulse, idle after release.
- REQ-038 Pending write landing on expiring wrap (dur=1) -> reload, no done_pulse, ch_active stays 1.

Source files
------------

// File: rtl/tone_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_pkg
//  Description : Shared constants, channel configuration record and helpers
//                for the multi-channel tone generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_gen_pkg;

    localparam int c_def_num_ch = 2;
    localparam int c_def_cnt_w  = 32;
    localparam int c_def_dur_w  = 16;
    localparam int c_ch_idx_w   = 3;

    // One channel's note configuration at the default counter widths.
    typedef struct packed {
        logic [c_def_cnt_w-1:0] period;
        logic [c_def_cnt_w-1:0] duty;
        logic [c_def_dur_w-1:0] dur;
    } tone_cfg_t;

    // True when the configuration channel index addresses channel idx.
    function automatic logic ch_match(input logic [c_ch_idx_w-1:0] ch,
                                      input int unsigned           idx);
        return ({{(32-c_ch_idx_w){1'b0}}, ch} == idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen_chan.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_chan
//  Description : One square-wave tone channel: wrap counter, duty compare,
//                one-deep pending configuration slot applied at a wrap.
//                TONE_GEN_DURATION_EN enables the note-duration counter and
//                the done pulse; without it notes play until rewritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_gen_chan
    import tone_gen_pkg::*;
#(
    parameter int CNT_W = c_def_cnt_w,
    parameter int DUR_W = c_def_dur_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [DUR_W-1:0] wr_dur,
    output logic             pend_busy,
    output logic             ch_out,
    output logic             ch_active,
    output logic             done_pulse
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_duty;
    logic             r_active;
    logic             r_pend_valid;
    logic             r_out;

    logic             w_wrap;
    logic             w_load;
    logic             w_store;
    logic             w_expire;
    logic [CNT_W-1:0] w_src_period;
    logic [CNT_W-1:0] w_src_duty;

    // A wrap is the last cycle of a wave; new settings only land here or on
    // an idle channel so the output never shows a truncated wave.
    assign w_wrap       = r_active && (r_count == r_period);
    assign w_load       = (!r_active && wr_en) || (w_wrap && (r_pend_valid || wr_en));
    assign w_store      = wr_en && r_active && !w_wrap;
    assign w_src_period = r_pend_valid ? r_pend_period : wr_period;
    assign w_src_duty   = r_pend_valid ? r_pend_duty   : wr_duty;

`ifdef TONE_GEN_DURATION_EN
    logic [DUR_W-1:0] r_dur_rem;
    logic [DUR_W-1:0] r_pend_dur;
    logic             r_done;
    logic [DUR_W-1:0] w_src_dur;

    assign w_src_dur = r_pend_valid ? r_pend_dur : wr_dur;
    // Expiry only when no replacement note is waiting to take over.
    assign w_expire  = w_wrap && (r_dur_rem == DUR_W'(1)) && !w_load;

    // Remaining-duration counter, pending duration and done pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dur_rem  <= '0;
            r_pend_dur <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_load) begin
                r_dur_rem <= w_src_dur;
            end else if (w_wrap && (r_dur_rem != '0)) begin
                r_dur_rem <= r_dur_rem - 1'b1;
            end
            if (w_store) begin
                r_pend_dur <= wr_dur;
            end
            r_done <= w_expire;
        end
    end

    assign done_pulse = r_done;
`else
    logic w_unused_dur;

    assign w_unused_dur = ^wr_dur;
    assign w_expire     = 1'b0;
    assign done_pulse   = 1'b0;
`endif

    // Wave counter, active configuration, pending slot and registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_period      <= '0;
            r_duty        <= '0;
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_active      <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_out         <= 1'b0;
        end else begin
            if (w_load) begin
                r_period     <= w_src_period;
                r_duty       <= w_src_duty;
                r_count      <= '0;
                r_active     <= (w_src_period != '0);
                r_pend_valid <= 1'b0;
            end else begin
                if (w_store) begin
                    r_pend_valid  <= 1'b1;
                    r_pend_period <= wr_period;
                    r_pend_duty   <= wr_duty;
                end
                if (w_wrap) begin
                    r_count <= '0;
                    if (w_expire) begin
                        r_active <= 1'b0;
                    end
                end else if (r_active) begin
                    r_count <= r_count + 1'b1;
                end
            end
            r_out <= r_active && (r_count > r_duty);
        end
    end

    assign pend_busy = r_pend_valid;
    assign ch_out    = r_out;
    assign ch_active = r_active;

endmodule
`default_nettype wire

// File: rtl/tone_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_multi
//  Description : NUM_CH independent square-wave tone channels with a
//                valid/ready configuration port and an OR mixer.
//                TONE_GEN_DURATION_EN enables per-note duration and
//                done_pulse; undefined, notes play until rewritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_gen_multi
    import tone_gen_pkg::*;
#(
    parameter int NUM_CH = c_def_num_ch,
    parameter int CNT_W  = c_def_cnt_w,
    parameter int DUR_W  = c_def_dur_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [DUR_W-1:0]  cfg_dur,
    output logic [NUM_CH-1:0] ch_out,
    output logic              mix_out,
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] done_pulse
);

    logic [NUM_CH-1:0] w_pend_busy;
    logic [NUM_CH-1:0] w_wr_en;

    // Ready drops only when the addressed channel already holds a pending
    // write; out-of-range indices are always accepted and go nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_match(cfg_ch, i)) begin
                cfg_ready = !w_pend_busy[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_wr_en[gi] = cfg_valid && cfg_ready && ch_match(cfg_ch, gi);

            tone_gen_chan #(
                .CNT_W (CNT_W),
                .DUR_W (DUR_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_en      (w_wr_en[gi]),
                .wr_period  (cfg_period),
                .wr_duty    (cfg_duty),
                .wr_dur     (cfg_dur),
                .pend_busy  (w_pend_busy[gi]),
                .ch_out     (ch_out[gi]),
                .ch_active  (ch_active[gi]),
                .done_pulse (done_pulse[gi])
            );
        end
    endgenerate

    assign mix_out = |ch_out;

endmodule
`default_nettype wire

// File: tb/tb_tone_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_gen_multi
//  Description : Directed self-checking bench for tone_gen_multi.
//                Expectations follow TONE_GEN_DURATION_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_gen_multi;
    import tone_gen_pkg::*;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;
    localparam int DUR_W  = 16;
`ifdef TONE_GEN_DURATION_EN
    localparam bit DUR_EN = 1'b1;
`else
    localparam bit DUR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_duty;
    logic [DUR_W-1:0]  cfg_dur;
    logic [NUM_CH-1:0] ch_out;
    logic              mix_out;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] done_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_gen_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DUR_W  (DUR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_dur    (cfg_dur),
        .ch_out     (ch_out),
        .mix_out    (mix_out),
        .ch_active  (ch_active),
        .done_pulse (done_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the write.
    task automatic cfg_write(input logic [2:0] ch, input tone_cfg_t c);
        cfg_ch     = ch;
        cfg_period = c.period;
        cfg_duty   = c.duty;
        cfg_dur    = c.dur;
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [1:10] pat;
        logic        saw_done;

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_dur    = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ch_out", ch_out, 0);
        check("rst_mix", mix_out, 0);
        check("rst_active", ch_active, 0);
        check("rst_done", done_pulse, 0);
        check("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle ch0: period 9, duty 4 -> 5 low, 5 high
        cfg_write(3'd0, tone_cfg_t'{32'd9, 32'd4, 16'd0});
        check("b_active", ch_active, 2'b01);
        check("b_out0", ch_out, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("b_ch0_wave", ch_out[0], ((k - 1) % 10) > 4);
            check("b_mix_wave", mix_out, ((k - 1) % 10) > 4);
        end

        // ch1: period 3, duty 1, dur 2 while ch0 keeps running
        cfg_write(3'd1, tone_cfg_t'{32'd3, 32'd1, 16'd2});
        check("c_active1", ch_active[1], 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("c_ch1_out", ch_out[1], (k == 3) || (k == 4) || (k == 7) || (k == 8));
            check("c_ch1_active", ch_active[1], DUR_EN ? (k <= 7) : 1'b1);
            check("c_ch1_done", done_pulse[1], DUR_EN && (k == 8));
            check("c_ch0_indep", ch_out[0], (k % 10) > 4);
        end

        // Out-of-range channel index: accepted, no effect
        cfg_ch     = 3'd5;
        cfg_period = 32'd7;
        cfg_duty   = 32'd0;
        cfg_dur    = 16'd1;
        cfg_valid  = 1'b1;
        #1;
        check("d_ready_ch5", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("d_active", ch_active, DUR_EN ? 2'b01 : 2'b11);
        check("d_done", done_pulse, 0);
        cfg_ch = 3'd0;
        #1;
        check("d_ready_ch0", cfg_ready, 1);
        cfg_ch = 3'd1;
        #1;
        check("d_ready_ch1", cfg_ready, 1);

        // Pending write on an active channel
        pulse_reset();
        check("e_idle", ch_active, 0);
        cfg_write(3'd0, tone_cfg_t'{32'd99, 32'd49, 16'd0});
        repeat (50) @(negedge clk);
        cfg_ch     = 3'd0;
        cfg_period = 32'd9;
        cfg_duty   = 32'd4;
        cfg_dur    = 16'd0;
        cfg_valid  = 1'b1;
        #1;
        check("e_ready_first", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("e_ready_ch0_pend", cfg_ready, 0);
        cfg_ch = 3'd1;
        #1;
        check("e_ready_ch1", cfg_ready, 1);
        cfg_ch     = 3'd0;
        cfg_period = 32'd19;
        cfg_duty   = 32'd9;
        cfg_valid  = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("e_wait_wrap", n, 49);
        check("e_last_old", ch_out[0], 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("e_new_wave1", ch_out[0], 0);
        #1;
        check("e_ready_second_pend", cfg_ready, 0);
        for (int j = 2; j <= 10; j++) begin
            @(negedge clk);
            check("e_new_wave", ch_out[0], ((j - 1) % 10) > 4);
        end
        check("e_ready_after_wrap", cfg_ready, 1);

        // Pending write lands on the expiring wrap
        pulse_reset();
        cfg_write(3'd1, tone_cfg_t'{32'd3, 32'd1, 16'd1});
        cfg_write(3'd1, tone_cfg_t'{32'd5, 32'd2, 16'd0});
        pat = 10'b0011000111;
        check("f_out", ch_out[1], pat[1]);
        check("f_active", ch_active[1], 1);
        check("f_done", done_pulse[1], 0);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            check("f_out", ch_out[1], pat[k]);
            check("f_active", ch_active[1], 1);
            check("f_done", done_pulse[1], 0);
        end

        // Asynchronous reset mid-note on both channels
        cfg_write(3'd0, tone_cfg_t'{32'd9, 32'd0, 16'd3});
        repeat (3) @(negedge clk);
        check("g_mix_pre", mix_out, 1);
        check("g_active_pre", ch_active, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("g_out_async", ch_out, 0);
        check("g_mix_async", mix_out, 0);
        check("g_active_async", ch_active, 0);
        check("g_done_async", done_pulse, 0);
        check("g_ready_async", cfg_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            saw_done = saw_done | (|done_pulse) | (|ch_active) | (|ch_out);
        end
        check("g_idle_after_release", saw_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
